// File: rtl/jtkicker_dwnld_if.sv
// Purpose : bundles the ioctl download stream and the SDRAM write port of jtkicker_dwnld.
// Ports   : ioctl_addr/ioctl_data/ioctl_wr in, ioctl_busy back; sdram_req/addr/din/dsn out, sdram_ack back.
// Modports: master = the download translator (drives SDRAM side), slave = downloader + SDRAM controller.
interface jtkicker_dwnld_if #(
  parameter int AW = 22
);
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_data;
  logic          ioctl_wr;
  logic          ioctl_busy;
  logic          sdram_req;
  logic [AW-2:0] sdram_addr;
  logic [15:0]   sdram_din;
  logic [1:0]    sdram_dsn;
  logic          sdram_ack;

  modport master (
    input  ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
    output ioctl_busy, sdram_req, sdram_addr, sdram_din, sdram_dsn
  );

  modport slave (
    output ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
    input  ioctl_busy, sdram_req, sdram_addr, sdram_din, sdram_dsn
  );
endinterface

// File: rtl/jtkicker_dwnld.sv
// Purpose : ROM download address translator (per-region bit permutation) feeding a small
//           write FIFO and a req/ack SDRAM byte-write engine.
// Latency : ioctl_wr in cycle N -> stage-1 N+1, FIFO N+2, sdram_req N+3 (when the engine is idle).
// Backpr. : ioctl_busy (registered, FIFO count >= DEPTH-1) leaves one slot for the stage-1 entry;
//           a push into a full FIFO drops the byte and sets the sticky overflow flag.
// Ports   : clk, rst_n (async active-low); region_start/region_mode tables; dwn_end level in;
//           bus (jtkicker_dwnld_if.master) carries ioctl stream and SDRAM write port;
//           overflow, dwn_done, sum out.
// Option  : define JTKICKER_DWNLD_SUM_EN to build the 16-bit byte checksum on sum; otherwise sum=0.
module jtkicker_dwnld #(
  parameter int AW      = 22,
  parameter int REGIONS = 4,
  parameter int DEPTH   = 4
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REGIONS*AW-1:0] region_start,
  input  logic [REGIONS*2-1:0]  region_mode,
  input  logic                  dwn_end,
  output logic                  overflow,
  output logic                  dwn_done,
  output logic [15:0]           sum,
  jtkicker_dwnld_if.master      bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] BUSY_CNT = CW'(DEPTH - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } entry_t;

  // region 0 has an implicit start of 0, so its table slice carries no information
  logic unused_region0;
  assign unused_region0 = ^region_start[AW-1:0];

  // ---------------- region select + permutation ----------------
  logic [1:0]    sel_mode;
  logic [AW-1:0] pre;
  logic [AW-1:0] post;

  assign pre = bus.ioctl_addr;

  // ascending scan, later hits override: highest matching index wins on overlap
  always_comb begin
    sel_mode = region_mode[1:0];
    for (int i = 1; i < REGIONS; i++) begin
      if (pre >= region_start[i*AW +: AW]) sel_mode = region_mode[i*2 +: 2];
    end
  end

  always_comb begin
    post = pre;
    case (sel_mode)
      2'd1: begin
        post[0]   = ~pre[3];
        post[3:1] = pre[2:0];
      end
      2'd2: begin
        post[0]   = ~pre[3];
        post[1]   = ~pre[4];
        post[5:2] = {pre[5], pre[2:0]};
      end
      2'd3: post[0] = ~pre[0];
      default: ;
    endcase
  end

  // ---------------- state ----------------
  logic          s1_vld_q, s1_vld_d;
  entry_t        s1_q, s1_d;
  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:0]    state_q, state_d;
  logic          req_q, req_d;
  logic [AW-2:0] addr_q, addr_d;
  logic [15:0]   din_q, din_d;
  logic [1:0]    dsn_q, dsn_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;

  logic   push, pop, full, drop;
  entry_t head;

  assign head = mem_q[rd_ptr_q];
  assign full = (cnt_q == FULL_CNT);
  assign pop  = (state_q == ST_IDLE) && (cnt_q != '0);
  // a same-cycle pop frees the slot the push needs, so a full FIFO still accepts then
  assign push = s1_vld_q && (!full || pop);
  assign drop = s1_vld_q && full && !pop;

  always_comb begin
    s1_vld_d = bus.ioctl_wr;
    s1_d     = s1_q;
    if (bus.ioctl_wr) s1_d = '{addr: post, data: bus.ioctl_data};

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);

    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dsn_d   = dsn_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          addr_d  = head.addr[AW-1:1];
          din_d   = {head.data, head.data};
          dsn_d   = head.addr[0] ? 2'b01 : 2'b10;
          req_d   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      default: begin
        if (bus.sdram_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase

    busy_d = (cnt_d >= BUSY_CNT);
    ovf_d  = ovf_q | drop;
    done_d = dwn_end && (cnt_q == '0) && !s1_vld_q && (state_q == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      dsn_q    <= 2'b11;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_q     <= s1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      dsn_q    <= dsn_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // storage needs no reset: occupancy is tracked entirely by the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s1_q;
  end

`ifdef JTKICKER_DWNLD_SUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (push) sum_d = sum_q + {8'd0, s1_q.data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign sum = sum_q;
`else
  assign sum = 16'd0;
`endif

  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = addr_q;
  assign bus.sdram_din  = din_q;
  assign bus.sdram_dsn  = dsn_q;
  assign bus.ioctl_busy = busy_q;
  assign overflow       = ovf_q;
  assign dwn_done       = done_q;
endmodule

// File: tb/tb_jtkicker_dwnld.sv
`timescale 1ns/1ps
module tb_jtkicker_dwnld;
  localparam int AW      = 22;
  localparam int REGIONS = 4;
  localparam int DEPTH   = 4;
`ifdef JTKICKER_DWNLD_SUM_EN
  localparam bit SUM_ON = 1'b1;
`else
  localparam bit SUM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]         rstart [REGIONS];
  logic [1:0]            rmode  [REGIONS];
  logic [REGIONS*AW-1:0] region_start;
  logic [REGIONS*2-1:0]  region_mode;
  logic                  dwn_end;
  logic                  overflow, dwn_done;
  logic [15:0]           sum;

  for (genvar g = 0; g < REGIONS; g++) begin : g_pack
    assign region_start[g*AW +: AW] = rstart[g];
    assign region_mode[g*2 +: 2]    = rmode[g];
  end

  jtkicker_dwnld_if #(.AW(AW)) bus ();

  jtkicker_dwnld #(.AW(AW), .REGIONS(REGIONS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .region_start(region_start), .region_mode(region_mode),
    .dwn_end(dwn_end), .overflow(overflow), .dwn_done(dwn_done), .sum(sum),
    .bus(bus)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-2:0] waddr;
    logic [15:0]   din;
    logic [1:0]    dsn;
  } wr_t;

  wr_t         expq [$];
  int unsigned model_sum;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [AW-1:0] model_post(input logic [AW-1:0] a);
    int            r;
    logic [AW-1:0] p;
    r = 0;
    for (int i = 1; i < REGIONS; i++) if (a >= rstart[i]) r = i;
    p = a;
    case (rmode[r])
      2'd1: p[3:0] = {a[2:0], ~a[3]};
      2'd2: p[5:0] = {a[5], a[2:0], ~a[4], ~a[3]};
      2'd3: p[0]   = ~a[0];
      default: ;
    endcase
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [AW-1:0] a, input logic [7:0] d, input bit accept);
    logic [AW-1:0] p;
    wr_t           e;
    p = model_post(a);
    bus.ioctl_addr = a;
    bus.ioctl_data = d;
    bus.ioctl_wr   = 1'b1;
    if (accept) begin
      e.waddr = (AW-1)'(p / 2);
      e.din   = {d, d};
      e.dsn   = (p % 2 == 1) ? 2'b01 : 2'b10;
      expq.push_back(e);
      model_sum += d;
    end
    tick();
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!bus.sdram_req && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_req_seen"}, bus.sdram_req, 1);
  endtask

  // accept one SDRAM request after `dly` stall cycles, comparing it to the scoreboard
  task automatic serve(input string tag, input int dly);
    wr_t           e;
    logic [AW-2:0] a0;
    wait_req(tag);
    if (expq.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = expq.pop_front();
      chk({tag, "_addr"}, bus.sdram_addr, e.waddr);
      chk({tag, "_din"},  bus.sdram_din,  e.din);
      chk({tag, "_dsn"},  bus.sdram_dsn,  e.dsn);
    end
    a0 = bus.sdram_addr;
    for (int i = 0; i < dly; i++) begin
      tick();
      chk({tag, "_req_hold"},  bus.sdram_req,  1);
      chk({tag, "_addr_hold"}, bus.sdram_addr, a0);
    end
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    chk({tag, "_req_drop"}, bus.sdram_req, 0);
  endtask

  function automatic logic [15:0] exp_sum();
    return SUM_ON ? 16'(model_sum) : 16'd0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    int            seen;
    bus.ioctl_addr = '0;
    bus.ioctl_data = '0;
    bus.ioctl_wr   = 1'b0;
    bus.sdram_ack  = 1'b0;
    dwn_end        = 1'b0;
    model_sum      = 0;
    rstart[0] = 22'h12345;       // region 0 start must be ignored
    rmode[0]  = 2'd0;
    rstart[1] = 22'h10000; rmode[1] = 2'd1;
    rstart[2] = 22'h20000; rmode[2] = 2'd2;
    rstart[3] = 22'h3FFFFF; rmode[3] = 2'd3;

    // ---- reset state ----
    #12;
    chk("rst_req",  bus.sdram_req, 0);
    chk("rst_addr", bus.sdram_addr, 0);
    chk("rst_din",  bus.sdram_din, 0);
    chk("rst_dsn",  bus.sdram_dsn, 2'b11);
    chk("rst_busy", bus.ioctl_busy, 0);
    chk("rst_ovf",  overflow, 0);
    chk("rst_done", dwn_done, 0);
    chk("rst_sum",  sum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---- tile mode, exact N+3 latency ----
    drive_wr(22'h10005, 8'hA5, 1);          // edge N+1
    tick();                                 // edge N+2
    chk("m1_req_n2", bus.sdram_req, 0);
    tick();                                 // edge N+3
    chk("m1_req_n3", bus.sdram_req, 1);
    chk("m1_addr_c", bus.sdram_addr, 22'h8005);
    chk("m1_dsn_c",  bus.sdram_dsn, 2'b01);
    chk("m1_din_c",  bus.sdram_din, 16'hA5A5);
    serve("m1", 0);

    // ---- stray ack while idle ----
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    tick();
    chk("idle_ack_req", bus.sdram_req, 0);

    // ---- sprite mode ----
    drive_wr(22'h20000, 8'h3C, 1);
    wait_req("m2a");
    chk("m2a_addr_c", bus.sdram_addr, 22'h10001);
    chk("m2a_dsn_c",  bus.sdram_dsn, 2'b01);
    serve("m2a", 1);
    drive_wr(22'h20018, 8'h5A, 1);
    serve("m2b", 2);

    // ---- overlap: highest index wins ----
    rstart[1] = 22'h100; rmode[1] = 2'd1;
    rstart[2] = 22'h080; rmode[2] = 2'd3;
    drive_wr(22'h180, 8'h77, 1);
    wait_req("ovl");
    chk("ovl_addr_c", bus.sdram_addr, 22'hC0);
    chk("ovl_dsn_c",  bus.sdram_dsn, 2'b01);
    serve("ovl", 0);
    tick();

    // ---- burst with ack held low: fill, busy, drop ----
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive_wr(22'($urandom_range(0, 22'h3FFFF)), 8'($urandom), i < DEPTH + 1);
      if (i == DEPTH - 1) chk("burst_busy_lo", bus.ioctl_busy, 0);
      if (i == DEPTH)     chk("burst_busy_hi", bus.ioctl_busy, 1);
    end
    chk("burst_ovf_pre", overflow, 0);
    tick();
    chk("burst_ovf_set", overflow, 1);
    chk("burst_busy_full", bus.ioctl_busy, 1);
    for (int i = 0; i < DEPTH + 1; i++) serve("drain", $urandom_range(0, 3));
    tick();
    chk("drain_busy", bus.ioctl_busy, 0);
    chk("drain_ovf_sticky", overflow, 1);
    chk("drain_sb", expq.size(), 0);
    chk("drain_sum", sum, exp_sum());

    // ---- randomized rounds ----
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < REGIONS; i++) begin
        rstart[i] = 22'($urandom_range(0, 22'h3FFFF));
        rmode[i]  = 2'($urandom);
      end
      fork
        begin
          for (int k = 0; k < 20; k++) begin
            int n;
            n = 0;
            while (bus.ioctl_busy && n < 200) begin
              tick();
              n++;
            end
            chk("rnd_slot", bus.ioctl_busy, 0);
            drive_wr(22'($urandom_range(0, 22'h3FFFF)), 8'($urandom), 1);
            repeat ($urandom_range(1, 3)) tick();
          end
        end
        begin
          for (int k = 0; k < 20; k++) serve("rnd", $urandom_range(0, 4));
        end
      join
      tick();
      chk("rnd_sb", expq.size(), 0);
      chk("rnd_sum", sum, exp_sum());
    end
    chk("rnd_ovf_sticky", overflow, 1);

    // ---- reset while a request is outstanding ----
    drive_wr(22'h00042, 8'h99, 1);
    wait_req("rstmid");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_req",  bus.sdram_req, 0);
    chk("rstmid_addr", bus.sdram_addr, 0);
    chk("rstmid_din",  bus.sdram_din, 0);
    chk("rstmid_dsn",  bus.sdram_dsn, 2'b11);
    chk("rstmid_ovf",  overflow, 0);
    chk("rstmid_sum",  sum, 0);
    expq.delete();
    model_sum = 0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (bus.sdram_req) seen++;
    end
    chk("rstmid_no_req", seen, 0);

    // ---- dwn_done and checksum ----
    dwn_end = 1'b1;
    tick();
    chk("done_empty", dwn_done, 1);
    a = 22'h00010;
    drive_wr(a, 8'hFF, 1);
    tick();
    drive_wr(a + 22'd3, 8'h02, 1);
    chk("done_busy1", dwn_done, 0);
    serve("dn1", 5);
    chk("done_mid", dwn_done, 0);
    serve("dn2", 5);
    chk("done_at_ack", dwn_done, 0);
    tick();
    chk("done_after", dwn_done, 1);
    chk("done_sum", sum, SUM_ON ? 16'h0101 : 16'h0000);
    dwn_end = 1'b0;
    tick();
    chk("done_fall", dwn_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
